// File: rtl/z_result_drain_if.sv
// ALU-result / datapath-bus bundle for z_result_drain.
// Z_FLAGS_EN adds the z_zero / z_neg branch-condition flags.
interface z_result_drain_if #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic [2*DATA_W-1:0] z_in;
   logic                z_two_beat;
   logic                z_valid;
   logic                z_ready;
   logic [DATA_W-1:0]   bus_out;
   logic                bus_hi;
   logic                bus_last;
   logic                bus_valid;
   logic                bus_ready;
   logic [CW-1:0]       count;
`ifdef Z_FLAGS_EN
   logic                z_zero;
   logic                z_neg;
`endif

   modport master (
      output z_in, z_two_beat, z_valid, bus_ready,
      input  z_ready, bus_out, bus_hi, bus_last, bus_valid, count
`ifdef Z_FLAGS_EN
      , input z_zero, z_neg
`endif
   );

   modport slave (
      input  z_in, z_two_beat, z_valid, bus_ready,
      output z_ready, bus_out, bus_hi, bus_last, bus_valid, count
`ifdef Z_FLAGS_EN
      , output z_zero, z_neg
`endif
   );
endinterface

// File: rtl/z_result_drain.sv
// Buffers 64-bit ALU results and drains them as ZLow[/ZHigh] beats on the 32-bit bus.
// Optional macro Z_FLAGS_EN adds registered z_zero / z_neg result flags.
module z_result_drain #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 2
) (
   input logic              clock,
   input logic              clear,
   z_result_drain_if.slave  zif
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;
   localparam int EW = 2*DATA_W + 1;
   localparam logic [CW-1:0] C_FULL = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOW  = 2'd1,
      S_HIGH = 2'd2
   } state_t;

   state_t            r_state;
   logic [EW-1:0]     r_mem [DEPTH];
   logic [PW-1:0]     r_wptr;
   logic [PW-1:0]     r_rptr;
   logic [CW-1:0]     r_count;
   logic [DATA_W-1:0] r_bus_out;
   logic              r_bus_hi;
   logic              r_bus_last;
   logic              r_bus_valid;

   logic [EW-1:0]     w_in_entry;
   logic [EW-1:0]     w_head;
   logic [PW-1:0]     w_rptr_inc;
   logic              w_push;
   logic              w_xfer;
   logic              w_pop;
   logic [CW-1:0]     w_count_nxt;
   logic [DATA_W-1:0] w_nxt_low;
   logic              w_nxt_two;

   assign w_in_entry  = {zif.z_two_beat, zif.z_in};
   assign zif.z_ready = (r_count != C_FULL);
   assign w_push      = zif.z_valid && zif.z_ready;
   assign w_xfer      = r_bus_valid && zif.bus_ready;
   assign w_pop       = w_xfer && r_bus_last;
   assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
   assign w_head      = r_mem[r_rptr];
   assign w_rptr_inc  = r_rptr + PW'(1);

   // When the only buffered entry pops while a new one arrives, the next head is
   // still on z_in (not yet in r_mem), so bypass it straight into the beat register.
   assign w_nxt_low = (r_count == CW'(1)) ? zif.z_in[DATA_W-1:0]
                                          : r_mem[w_rptr_inc][DATA_W-1:0];
   assign w_nxt_two = (r_count == CW'(1)) ? zif.z_two_beat
                                          : r_mem[w_rptr_inc][EW-1];

   always_ff @(posedge clock) begin
      if (w_push) r_mem[r_wptr] <= w_in_entry;
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_state     <= S_IDLE;
         r_wptr      <= '0;
         r_rptr      <= '0;
         r_count     <= '0;
         r_bus_out   <= '0;
         r_bus_hi    <= 1'b0;
         r_bus_last  <= 1'b0;
         r_bus_valid <= 1'b0;
      end else begin
         r_count <= w_count_nxt;
         if (w_push) r_wptr <= r_wptr + PW'(1);
         if (w_pop)  r_rptr <= w_rptr_inc;

         case (r_state)
            S_IDLE: begin
               if (r_count != '0) begin
                  r_state     <= S_LOW;
                  r_bus_out   <= w_head[DATA_W-1:0];
                  r_bus_hi    <= 1'b0;
                  r_bus_last  <= !w_head[EW-1];
                  r_bus_valid <= 1'b1;
               end
            end
            S_LOW, S_HIGH: begin
               if (w_xfer) begin
                  if (!r_bus_last) begin
                     r_state    <= S_HIGH;
                     r_bus_out  <= w_head[2*DATA_W-1:DATA_W];
                     r_bus_hi   <= 1'b1;
                     r_bus_last <= 1'b1;
                  end else if (w_count_nxt != '0) begin
                     r_state    <= S_LOW;
                     r_bus_out  <= w_nxt_low;
                     r_bus_hi   <= 1'b0;
                     r_bus_last <= !w_nxt_two;
                  end else begin
                     r_state     <= S_IDLE;
                     r_bus_hi    <= 1'b0;
                     r_bus_last  <= 1'b0;
                     r_bus_valid <= 1'b0;
                  end
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_bus_valid <= 1'b0;
            end
         endcase
      end
   end

   assign zif.bus_out   = r_bus_out;
   assign zif.bus_hi    = r_bus_hi;
   assign zif.bus_last  = r_bus_last;
   assign zif.bus_valid = r_bus_valid;
   assign zif.count     = r_count;

`ifdef Z_FLAGS_EN
   logic r_z_zero;
   logic r_z_neg;

   // Head is still valid in r_mem on its final-beat edge, so the full result is visible.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         r_z_zero <= 1'b0;
         r_z_neg  <= 1'b0;
      end else if (w_pop) begin
         r_z_zero <= w_head[EW-1] ? (w_head[2*DATA_W-1:0] == '0)
                                  : (w_head[DATA_W-1:0] == '0);
         r_z_neg  <= r_bus_out[DATA_W-1];
      end
   end

   assign zif.z_zero = r_z_zero;
   assign zif.z_neg  = r_z_neg;
`endif
endmodule

// File: doc/z_result_drain.md
Name: z_result_drain

Overview:
- Receiving end of the ALU result interface. Accepts the 64-bit Z result plus a two-beat flag, buffers up to DEPTH results, and drains each onto the 32-bit datapath bus in ZLow/ZHigh beats.
- Single-beat ops (ADD, SUB, logic, shifts, NOT, NEG) send ZLow only.
- Two-beat ops (MUL, DIV) send ZLow, then ZHigh (LO then HI).
- Decouples ALU issue timing from bus/register-write timing.

Parameters:
- DATA_W, 32, bus width; Z width is 2*DATA_W.
- DEPTH, 2, result buffer entries; power of two, at least 2.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous, active-high reset.
- z_in  in  2*DATA_W  ALU result; [DATA_W-1:0]=ZLow, [2*DATA_W-1:DATA_W]=ZHigh.
- z_two_beat  in  1  qualifies z_in; 1 = MUL/DIV result, drain both halves.
- z_valid  in  1  z_in/z_two_beat valid.
- z_ready  out  1  buffer can accept; high when not full.
- bus_out  out  DATA_W  beat data.
- bus_hi  out  1  0 = beat is ZLow/LO, 1 = beat is ZHigh/HI.
- bus_last  out  1  final beat of the current result.
- bus_valid  out  1  beat valid.
- bus_ready  in  1  bus/register file takes the beat.
- count  out  $clog2(DEPTH)+1  buffered results, including the one draining.

Behaviour:
- Handshakes:
  - Input transfer when z_valid && z_ready.
  - Output beat transfer when bus_valid && bus_ready.
  - All state updates on the rising clock edge.
- Buffer:
  - Circular FIFO of {z_two_beat, z_in}.
  - Write and read pointers wrap modulo DEPTH.
  - count is registered.
- z_ready = (count != DEPTH). Combinational from count only; no dependence on bus_ready.
- Simultaneous push and final-beat pop when full: not allowed. z_ready is low, so the push is refused.
- Simultaneous push and pop when not full: both take effect; count unchanged.
- Drain FSM states: IDLE, LOW, HIGH.
  - IDLE: bus_valid=0. Moves to LOW on the cycle after count becomes nonzero.
  - LOW:
    - bus_out = ZLow of head, bus_hi=0, bus_valid=1, bus_last = !two_beat.
    - On transfer with two_beat=1: go to HIGH.
    - On transfer with two_beat=0: pop head, then stay in LOW if count after pop is nonzero, else go to IDLE.
  - HIGH:
    - bus_out = ZHigh of head, bus_hi=1, bus_valid=1, bus_last=1.
    - On transfer: pop head, then go to LOW or IDLE by the same rule.
- Latency: first beat is presented 1 cycle after the accepting edge. Steady state sustains one beat per cycle.
- Output stability: while bus_valid=1 && bus_ready=0, bus_out, bus_hi and bus_last hold stable.
- Outputs are registered. bus_out is driven from a register loaded at state entry, not combinationally from the FIFO head.
- Reset (clear=1, any time including mid-drain):
  - State goes to IDLE; pointers and count go to 0.
  - bus_valid=0, bus_out=0, bus_hi=0, bus_last=0.
  - z_ready=1 once clear deasserts.
  - Buffered results are discarded.
- Inputs are not checked. z_in X values while z_valid=0 must never propagate to bus_out.

Optional Feature:
- Macro: Z_FLAGS_EN.
- Defined:
  - Adds outputs z_zero (1) and z_neg (1), registered on each final-beat transfer.
  - z_zero = (full 64-bit result == 0) for two-beat results, (ZLow == 0) otherwise.
  - z_neg = MSB of the last beat sent.
  - Both reset to 0; both hold between results. Used for branch-condition logic.
- Undefined: ports absent, no flag logic.

Test Plan:
- Single op: push z_in=64'h0000_0000_0000_0007, two_beat=0, bus_ready=1 -> one beat, bus_out=7, bus_hi=0, bus_last=1, one cycle after accept; count returns 0.
- MUL: push z_in=64'h0000_0001_8000_0000, two_beat=1 -> beat 1 = 32'h8000_0000 (bus_hi=0, last=0), beat 2 = 32'h0000_0001 (bus_hi=1, last=1).
- Backpressure/full: bus_ready=0, push three results with DEPTH=2 -> z_ready falls after 2 accepts; third held off; bus_out stable on ZLow of first. Release bus_ready -> all three drain in order, correct bus_hi sequence.
- Wrap-around: stream 10 alternating single/two-beat results with bus_ready toggling pseudo-randomly -> beat sequence matches scoreboard exactly; pointers wrap; count never exceeds 2.
- Reset mid-drain: clear asserted during HIGH of a DIV result -> same cycle bus_valid=0, count=0; after release z_ready=1 and the next pushed result drains from LOW.
- Z_FLAGS_EN: results 0 (two-beat), then 32'hFFFF_FFFF (single) -> z_zero=1, z_neg=0 after first; z_zero=0, z_neg=1 after second.
